// File: rtl/clk_div_meter.sv
// clk_div_meter: measures high time, low time and period of a (possibly
// asynchronous) divided clock in CLK_IN cycles, with duty-symmetry, lock
// and sticky timeout status.
module clk_div_meter #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1000,
    parameter int LOCK_NUM    = 4
) (
    input  logic             CLK_IN,
    input  logic             RST,
    input  logic             MEAS_EN,
    input  logic             SIG_IN,
    output logic [CNT_W-1:0] HIGH_CNT,
    output logic [CNT_W-1:0] LOW_CNT,
    output logic [CNT_W-1:0] PERIOD,
    output logic             VALID,
    output logic             DUTY_OK,
    output logic             LOCKED,
    output logic             TIMEOUT
);

    typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

    localparam logic [CNT_W-1:0] TO_MAX   = CNT_W'(TIMEOUT_CYC);
    // Timeout fires on the cycle cnt would step onto TIMEOUT_CYC, so the
    // flag rises exactly TIMEOUT_CYC cycles after the last detected edge.
    localparam logic [CNT_W-1:0] TO_PRE   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]       LOCK_MAX = 4'(LOCK_NUM);

    state_t           state, state_nxt;
    logic             s1, s2, s3;
    logic             rise, fall;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] h_tmp;
    logic [3:0]       lock_cnt;
    logic [3:0]       lock_nxt;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] per_sat;
    logic [CNT_W-1:0] diff;
    logic             start, capture_h, done, tmo;

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // Two-flop synchronizer plus one delay flop for edge detection.
    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= SIG_IN;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Segment counter: restarts at 1 on every edge, saturates at the timeout.
    always_ff @(posedge CLK_IN) begin
        if (RST)
            cnt <= '0;
        else if (rise || fall)
            cnt <= CNT_W'(1);
        else if (cnt != TO_MAX)
            cnt <= cnt + CNT_W'(1);
    end

    // State register.
    always_ff @(posedge CLK_IN) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; MEAS_EN low always returns to IDLE.
    always_comb begin
        state_nxt = state;
        if (!MEAS_EN) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:      state_nxt = WAIT_RISE;
                WAIT_RISE: if (rise) state_nxt = MEAS_HIGH;
                MEAS_HIGH: if (fall) state_nxt = MEAS_LOW;
                           else if (tmo) state_nxt = WAIT_RISE;
                MEAS_LOW:  if (rise) state_nxt = MEAS_HIGH;
                           else if (tmo) state_nxt = WAIT_RISE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    // FSM outputs: datapath strobes decoded from state and edges.
    always_comb begin
        start     = (state == IDLE) && MEAS_EN;
        capture_h = (state == MEAS_HIGH) && MEAS_EN && fall;
        done      = (state == MEAS_LOW) && MEAS_EN && rise;
        tmo       = ((state == MEAS_HIGH) || (state == MEAS_LOW)) && MEAS_EN &&
                    !(rise || fall) && (cnt == TO_PRE);
    end

    // Result arithmetic: saturating period, |high-low|, next lock count.
    always_comb begin
        sum      = {1'b0, h_tmp} + {1'b0, cnt};
        per_sat  = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        diff     = (h_tmp > cnt) ? (h_tmp - cnt) : (cnt - h_tmp);
        // lock_cnt == 0 means no reference period yet (after IDLE/timeout).
        if (lock_cnt != 4'd0 && per_sat == PERIOD)
            lock_nxt = (lock_cnt >= LOCK_MAX) ? LOCK_MAX : lock_cnt + 4'd1;
        else
            lock_nxt = 4'd1;
    end

    // Result and status registers; they hold while idle.
    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            h_tmp    <= '0;
            HIGH_CNT <= '0;
            LOW_CNT  <= '0;
            PERIOD   <= '0;
            VALID    <= 1'b0;
            DUTY_OK  <= 1'b0;
            LOCKED   <= 1'b0;
            TIMEOUT  <= 1'b0;
            lock_cnt <= '0;
        end else begin
            VALID <= done;
            if (start) begin
                TIMEOUT  <= 1'b0;
                lock_cnt <= '0;
            end
            if (capture_h)
                h_tmp <= cnt;
            if (done) begin
                HIGH_CNT <= h_tmp;
                LOW_CNT  <= cnt;
                PERIOD   <= per_sat;
                DUTY_OK  <= (diff <= CNT_W'(1));
                lock_cnt <= lock_nxt;
                LOCKED   <= (lock_nxt == LOCK_MAX);
            end
            if (tmo) begin
                TIMEOUT  <= 1'b1;
                LOCKED   <= 1'b0;
                lock_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_meter.sv
// tb_clk_div_meter: random and directed SIG_IN patterns against a
// timestamp-based model of the meter, checked every cycle.
module tb_clk_div_meter;

    localparam int CNT_W = 16;
    localparam int TO    = 1000;
    localparam int LN    = 4;

    logic             CLK_IN = 1'b0;
    logic             RST = 1'b1;
    logic             MEAS_EN = 1'b0;
    logic             SIG_IN = 1'b0;
    logic [CNT_W-1:0] HIGH_CNT, LOW_CNT, PERIOD;
    logic             VALID, DUTY_OK, LOCKED, TIMEOUT;

    clk_div_meter #(.CNT_W(CNT_W), .TIMEOUT_CYC(TO), .LOCK_NUM(LN)) dut (
        .CLK_IN(CLK_IN), .RST(RST), .MEAS_EN(MEAS_EN), .SIG_IN(SIG_IN),
        .HIGH_CNT(HIGH_CNT), .LOW_CNT(LOW_CNT), .PERIOD(PERIOD),
        .VALID(VALID), .DUTY_OK(DUTY_OK), .LOCKED(LOCKED), .TIMEOUT(TIMEOUT)
    );

    always #5 CLK_IN = ~CLK_IN;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Works on timestamps of level changes of the sampled input, delayed by
    // the synchronizer depth; periods are rise-to-fall plus fall-to-rise.
    bit  hist [4];
    int  m = 8;
    bit  model_ok = 0;
    bit  active = 0, armed = 0;
    int  rise_t = 0, fall_t = -1, last_edge = 0, lockc = 0;
    int  e_high = 0, e_low = 0, e_per = 0;
    bit  e_valid = 0, e_duty = 0, e_locked = 0, e_tmo = 0;

    always @(posedge CLK_IN) begin
        bit d, p;
        int h, l, ps;
        d = hist[(m - 2) & 3];
        p = hist[(m - 3) & 3];
        hist[m & 3] = SIG_IN;
        e_valid = 0;
        if (RST) begin
            e_high = 0; e_low = 0; e_per = 0;
            e_duty = 0; e_locked = 0; e_tmo = 0;
            lockc = 0; active = 0; armed = 0;
            hist[m & 3] = 0; hist[(m - 1) & 3] = 0; hist[(m - 2) & 3] = 0;
            model_ok = 1;
        end else if (!MEAS_EN) begin
            active = 0; armed = 0;
        end else if (!active) begin
            active = 1; armed = 0; e_tmo = 0; lockc = 0;
        end else begin
            if (d && !p) begin
                if (armed && fall_t >= 0) begin
                    h  = fall_t - rise_t;
                    l  = m - fall_t;
                    ps = (h + l > 65535) ? 65535 : h + l;
                    if (lockc != 0 && ps == e_per)
                        lockc = (lockc + 1 > LN) ? LN : lockc + 1;
                    else
                        lockc = 1;
                    e_high = h; e_low = l; e_per = ps;
                    e_duty = (h - l <= 1) && (l - h <= 1);
                    e_locked = (lockc == LN);
                    e_valid = 1;
                end
                armed = 1; rise_t = m; fall_t = -1;
            end else if (!d && p) begin
                if (armed) fall_t = m;
            end else if (armed && (m - last_edge) == TO - 1) begin
                e_tmo = 1; e_locked = 0; lockc = 0; armed = 0;
            end
        end
        if (d != p) last_edge = m;
        m++;
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge CLK_IN) begin
        if (model_ok) begin
            chk("HIGH_CNT", HIGH_CNT, e_high);
            chk("LOW_CNT",  LOW_CNT,  e_low);
            chk("PERIOD",   PERIOD,   e_per);
            chk("VALID",    VALID,    e_valid);
            chk("DUTY_OK",  DUTY_OK,  e_duty);
            chk("LOCKED",   LOCKED,   e_locked);
            chk("TIMEOUT",  TIMEOUT,  e_tmo);
        end
    end

    // ---------------- stimulus ----------------
    task automatic per(input int h, input int l, input int n);
        repeat (n) begin
            SIG_IN = 1'b1;
            repeat (h) @(negedge CLK_IN);
            SIG_IN = 1'b0;
            repeat (l) @(negedge CLK_IN);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge CLK_IN);
        chk("rst PERIOD", PERIOD, 0);
        chk("rst LOCKED", LOCKED, 0);
        chk("rst TIMEOUT", TIMEOUT, 0);
        chk("rst VALID", VALID, 0);
        RST = 1'b0;
        MEAS_EN = 1'b1;

        // high 2 / low 1
        per(2, 1, 12);
        chk("t1 HIGH_CNT", HIGH_CNT, 2);
        chk("t1 LOW_CNT", LOW_CNT, 1);
        chk("t1 PERIOD", PERIOD, 3);
        chk("t1 DUTY_OK", DUTY_OK, 1);
        chk("t1 LOCKED", LOCKED, 1);

        // high 5 / low 2, then high 4 / low 4
        per(5, 2, 8);
        chk("t2 PERIOD", PERIOD, 7);
        chk("t2 DUTY_OK", DUTY_OK, 0);
        chk("t2 LOCKED", LOCKED, 1);
        per(4, 4, 6);
        chk("t2b PERIOD", PERIOD, 8);
        chk("t2b DUTY_OK", DUTY_OK, 1);
        chk("t2b LOCKED", LOCKED, 1);

        // stuck high -> timeout
        SIG_IN = 1'b1;
        repeat (1500) @(negedge CLK_IN);
        chk("t3 TIMEOUT", TIMEOUT, 1);
        chk("t3 LOCKED", LOCKED, 0);
        chk("t3 PERIOD", PERIOD, 8);

        // toggling again, timeout sticky until re-enable
        per(3, 3, 8);
        chk("t4 TIMEOUT", TIMEOUT, 1);
        chk("t4 PERIOD", PERIOD, 6);
        chk("t4 LOCKED", LOCKED, 1);
        MEAS_EN = 1'b0;
        repeat (3) @(negedge CLK_IN);
        chk("t4 idle TIMEOUT", TIMEOUT, 1);
        MEAS_EN = 1'b1;
        repeat (2) @(negedge CLK_IN);
        chk("t4 clr TIMEOUT", TIMEOUT, 0);

        // reset during a low segment
        per(3, 3, 3);
        SIG_IN = 1'b1;
        repeat (3) @(negedge CLK_IN);
        SIG_IN = 1'b0;
        repeat (4) @(negedge CLK_IN);
        RST = 1'b1;
        @(negedge CLK_IN);
        RST = 1'b0;
        chk("t5 HIGH_CNT", HIGH_CNT, 0);
        chk("t5 PERIOD", PERIOD, 0);
        chk("t5 LOCKED", LOCKED, 0);
        chk("t5 DUTY_OK", DUTY_OK, 0);
        per(3, 3, 4);

        // divide-by-3 50% source seen as {2,1} or {1,2}
        repeat (12) begin
            if ($urandom_range(0, 1) != 0) per(2, 1, 1);
            else per(1, 2, 1);
        end
        chk("t6 PERIOD", PERIOD, 3);
        chk("t6 SUM", HIGH_CNT + LOW_CNT, 3);
        chk("t6 DUTY_OK", DUTY_OK, 1);
        chk("t6 LOCKED", LOCKED, 1);

        // random patterns with enable drops and resets
        repeat (200) begin
            int r;
            per($urandom_range(1, 7), $urandom_range(1, 7), $urandom_range(1, 6));
            r = $urandom_range(0, 19);
            if (r == 0) begin
                MEAS_EN = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge CLK_IN);
                MEAS_EN = 1'b1;
            end else if (r == 1) begin
                RST = 1'b1;
                @(negedge CLK_IN);
                RST = 1'b0;
            end
        end
        repeat (10) @(negedge CLK_IN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/clk_div_meter.md
Name: clk_div_meter

Overview:
- Measures a divided clock, such as the output of the odd/even clock dividers, against the system clock.
- Reports high time, low time and period in CLK_IN cycles, plus a duty-symmetry flag and a lock flag.
- Acts as the receiving end of the divider: a bench/self-check monitor and a runtime ratio detector that feeds the time manager status registers.

Parameters:
- CNT_W, 16, width of all cycle counters and result outputs.
- TIMEOUT_CYC, 1000, cycles without an expected edge before declaring TIMEOUT; must be < 2^CNT_W.
- LOCK_NUM, 4, consecutive identical PERIOD measurements required to assert LOCKED; range 1..15.

Ports:
- CLK_IN  input  1  system clock; all logic on posedge.
- RST  input  1  synchronous reset, active-high.
- MEAS_EN  input  1  1 = measure; 0 = return to IDLE and hold results.
- SIG_IN  input  1  divided clock under test; may be asynchronous.
- HIGH_CNT  output  CNT_W  cycles SIG was high in the last complete period.
- LOW_CNT  output  CNT_W  cycles SIG was low in the last complete period.
- PERIOD  output  CNT_W  HIGH_CNT+LOW_CNT, saturating at all-ones.
- VALID  output  1  one-cycle pulse when a new period result is written.
- DUTY_OK  output  1  |HIGH_CNT-LOW_CNT| <= 1 for the current result.
- LOCKED  output  1  PERIOD stable for LOCK_NUM consecutive results.
- TIMEOUT  output  1  sticky; expected edge not seen within TIMEOUT_CYC.

Behaviour:
- Reset (RST=1 at a posedge) clears:
  - synchronizer flops;
  - state to IDLE;
  - counters, HIGH_CNT, LOW_CNT and PERIOD to 0;
  - VALID, DUTY_OK, LOCKED, TIMEOUT and lock counter to 0.
- Input path: 2-flop synchronizer s1→s2, then delay flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Edge detection latency from SIG_IN change to rise/fall: 3 cycles (fixed, does not bias counts).
- Segment counter cnt:
  - loaded with 1 on a rise or fall cycle; otherwise cnt+1, saturating at TIMEOUT_CYC.
  - A segment length equals the number of cycles s2 held that level.
- FSM states: IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW.
  - IDLE: MEAS_EN=1 → WAIT_RISE. TIMEOUT is cleared on this entry.
  - WAIT_RISE: rise → MEAS_HIGH (cnt=1). Edges before the first rise are ignored, so a partial first period is never reported.
  - MEAS_HIGH: fall → h_tmp<=cnt, MEAS_LOW (cnt=1).
  - MEAS_LOW: rise → HIGH_CNT<=h_tmp, LOW_CNT<=cnt, PERIOD<=h_tmp+cnt (saturating), VALID=1 for that cycle, → MEAS_HIGH (cnt=1). Back-to-back periods are measured with no gap.
  - MEAS_HIGH or MEAS_LOW with cnt reaching TIMEOUT_CYC and no edge → TIMEOUT<=1, LOCKED<=0, lock counter<=0, → WAIT_RISE.
  - Any state with MEAS_EN=0 → IDLE next cycle. Outputs hold their values; a partial measurement is discarded.
- DUTY_OK is registered with the results; updates on the same cycle as VALID.
- Lock logic, evaluated on each VALID:
  - new PERIOD == previous PERIOD → lock counter increments, saturating at LOCK_NUM;
  - otherwise lock counter <= 1.
  - LOCKED = (lock counter == LOCK_NUM); it updates the same cycle as VALID.
  - The first result after IDLE or timeout sets lock counter to 1.
- RST has priority over everything. Reset mid-measurement yields no VALID pulse.

Test Plan:
1. SIG_IN periodic, high 2 / low 1 cycles, MEAS_EN=1 → first VALID after the 2nd rise seen; HIGH_CNT=2, LOW_CNT=1, PERIOD=3, DUTY_OK=1; LOCKED=1 on the 4th VALID.
2. SIG_IN high 5 / low 2 → PERIOD=7, DUTY_OK=0; then switch to high 4 / low 4 → first new result PERIOD=8, LOCKED drops to 0 that cycle and reasserts after 4 results.
3. SIG_IN held at 1 for 1500 cycles after a valid lock, TIMEOUT_CYC=1000 → TIMEOUT=1 exactly 1000 cycles after the last rise is detected; LOCKED=0; no VALID; results hold the old values.
4. Restore toggling after step 3 → measurement restarts at the next rise. TIMEOUT stays 1 until MEAS_EN 0→1, which clears it.
5. Assert RST for 1 cycle mid-MEAS_LOW → all outputs 0 the next cycle, state IDLE; with MEAS_EN still 1, measurement restarts and the first VALID follows two full rises.
6. Drive SIG_IN from a divide-by-3 XOR divider (50% duty) → every result has PERIOD=3, HIGH_CNT+LOW_CNT=3 with {2,1} or {1,2}, DUTY_OK=1, LOCKED=1 after 4 results.
